// File: rtl/fifo_flex.sv
// fifo_flex: parametrised synchronous FIFO for the PCIe switch datapath,
// between the per-lane demux and the arbiter/mux stages.
// It has runtime almost-full/almost-empty thresholds, a hysteretic upstream
// pause, an occupancy output and sticky overflow/underflow flags.
// Storage is an internal register array. The array is not reset.
// Optional feature: define FIFO_FWFT_EN for first-word fall-through reads.
// The default build uses a registered read path with 1-cycle latency.
module fifo_flex #(
  parameter int DATA_SIZE = 10,
  parameter int ADDR_W    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write,
  input  logic [DATA_SIZE-1:0] data_in_push,
  input  logic                 read,
  output logic [DATA_SIZE-1:0] data_out_pop,
  output logic                 data_valid,
  input  logic [ADDR_W:0]      th_almost_full,
  input  logic [ADDR_W:0]      th_almost_empty,
  input  logic                 err_clear,
  output logic [ADDR_W:0]      fifo_count,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 fifo_pause,
  output logic                 err_overflow,
  output logic                 err_underflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]    wr_ptr;
  logic [ADDR_W-1:0]    rd_ptr;
  logic [ADDR_W:0]      count;
  logic [ADDR_W:0]      count_next;
  logic                 wr_acc;
  logic                 rd_acc;

  // The flags decode from the registered count, so they change one edge after the access.
  assign fifo_count   = count;
  assign fifo_full    = (count == DEPTH_CNT);
  assign fifo_empty   = (count == '0);
  assign almost_full  = (count >= th_almost_full);
  assign almost_empty = (count != '0) && (count <= th_almost_empty);

  // A full FIFO rejects writes and an empty FIFO rejects reads, even when both are requested.
  assign wr_acc = write && !fifo_full;
  assign rd_acc = read && !fifo_empty;

  // Next occupancy. A simultaneous accepted push and pop leaves the count unchanged.
  always_comb begin
    count_next = count;
    if (wr_acc && !rd_acc)
      count_next = count + CNT_ONE;
    else if (rd_acc && !wr_acc)
      count_next = count - CNT_ONE;
  end

  // Storage write. The array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr] <= data_in_push;
  end

  // Pointers and occupancy. The pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc)
        rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_next;
    end
  end

  // Hysteretic pause, judged on the next count so it moves on the same edge as fifo_count.
  // The set condition wins when the thresholds overlap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      fifo_pause <= 1'b0;
    else if (count_next >= th_almost_full)
      fifo_pause <= 1'b1;
    else if (count_next <= th_almost_empty)
      fifo_pause <= 1'b0;
  end

  // Sticky error flags. A new error event in the same cycle overrides err_clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (write && fifo_full)
        err_overflow <= 1'b1;
      else if (err_clear)
        err_overflow <= 1'b0;
      if (read && fifo_empty)
        err_underflow <= 1'b1;
      else if (err_clear)
        err_underflow <= 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  // Fall-through: the head word is always presented. A read only acknowledges it.
  assign data_out_pop = mem[rd_ptr];
  assign data_valid   = !fifo_empty;
`else
  // Registered pop: the word appears one cycle after the read and then holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_pop <= '0;
      data_valid   <= 1'b0;
    end else begin
      data_valid <= rd_acc;
      if (rd_acc)
        data_out_pop <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_flex.sv
// tb_fifo_flex: self-checking bench for fifo_flex (DATA_SIZE=10, ADDR_W=3).
// A queue-based reference model tracks the FIFO from its behavioural rules.
// Every cycle is checked against that model.
// A vector table covers the fill-to-full and drain-to-empty walk.
// Hand-written sequences cover hysteresis, wrap, simultaneous access, errors and async reset.
// Randomised traffic is checked against the model last.
module tb_fifo_flex;

  localparam int DEPTH = 8;

  logic       clk;
  logic       reset;
  logic       write;
  logic [9:0] data_in_push;
  logic       read;
  logic [9:0] data_out_pop;
  logic       data_valid;
  logic [3:0] th_almost_full;
  logic [3:0] th_almost_empty;
  logic       err_clear;
  logic [3:0] fifo_count;
  logic       fifo_full;
  logic       fifo_empty;
  logic       almost_full;
  logic       almost_empty;
  logic       fifo_pause;
  logic       err_overflow;
  logic       err_underflow;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [9:0] model_q[$];
  logic       m_ovf, m_unf, m_pause, m_valid;
  logic [9:0] m_data;

  typedef struct {
    logic       wr;
    logic [9:0] din;
    logic       rd;
    logic       clr;
    logic [3:0] exp_count;
    logic       exp_full;
    logic       exp_empty;
    logic       exp_pause;
    logic       exp_ovf;
    logic       exp_unf;
    logic       exp_valid;
    logic [9:0] exp_data;
  } vec_t;

  vec_t vecs[19];

  fifo_flex #(.DATA_SIZE(10), .ADDR_W(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .write           (write),
    .data_in_push    (data_in_push),
    .read            (read),
    .data_out_pop    (data_out_pop),
    .data_valid      (data_valid),
    .th_almost_full  (th_almost_full),
    .th_almost_empty (th_almost_empty),
    .err_clear       (err_clear),
    .fifo_count      (fifo_count),
    .fifo_full       (fifo_full),
    .fifo_empty      (fifo_empty),
    .almost_full     (almost_full),
    .almost_empty    (almost_empty),
    .fifo_pause      (fifo_pause),
    .err_overflow    (err_overflow),
    .err_underflow   (err_underflow)
  );

  // free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t make_vec(logic wr, logic [9:0] din, logic rd, logic clr,
                                    logic [3:0] cnt, logic full, logic empty, logic pause,
                                    logic ovf, logic unf, logic valid, logic [9:0] dat);
    vec_t v;
    v.wr = wr; v.din = din; v.rd = rd; v.clr = clr;
    v.exp_count = cnt; v.exp_full = full; v.exp_empty = empty; v.exp_pause = pause;
    v.exp_ovf = ovf; v.exp_unf = unf; v.exp_valid = valid; v.exp_data = dat;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, actual, actual, expected, expected, $time);
    end
  endtask

  // compare every DUT output against the reference model
  task automatic compareModel();
    int sz;
    sz = model_q.size();
    checkOutput("count", int'(fifo_count), sz);
    checkOutput("full", int'(fifo_full), int'(sz == DEPTH));
    checkOutput("empty", int'(fifo_empty), int'(sz == 0));
    checkOutput("almost_full", int'(almost_full), int'(sz >= int'(th_almost_full)));
    checkOutput("almost_empty", int'(almost_empty),
                int'(sz != 0 && sz <= int'(th_almost_empty)));
    checkOutput("pause", int'(fifo_pause), int'(m_pause));
    checkOutput("err_overflow", int'(err_overflow), int'(m_ovf));
    checkOutput("err_underflow", int'(err_underflow), int'(m_unf));
`ifdef FIFO_FWFT_EN
    checkOutput("data_valid", int'(data_valid), int'(sz != 0));
    if (sz != 0)
      checkOutput("data_out_pop", int'(data_out_pop), int'(model_q[0]));
`else
    checkOutput("data_valid", int'(data_valid), int'(m_valid));
    checkOutput("data_out_pop", int'(data_out_pop), int'(m_data));
`endif
  endtask

  // drive one cycle of inputs, advance the model, and check after the edge
  task automatic applyStimulus(input logic w, input logic [9:0] d, input logic r,
                               input logic c);
    int  sz;
    bit  full, empty, wr_ok, rd_ok;
    write = w; data_in_push = d; read = r; err_clear = c;
    sz    = model_q.size();
    full  = (sz == DEPTH);
    empty = (sz == 0);
    wr_ok = w && !full;
    rd_ok = r && !empty;
    if (w && full) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
    if (r && empty) m_unf = 1'b1; else if (c) m_unf = 1'b0;
    if (rd_ok) begin
      m_data  = model_q.pop_front();
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (wr_ok) model_q.push_back(d);
    if (model_q.size() >= int'(th_almost_full)) m_pause = 1'b1;
    else if (model_q.size() <= int'(th_almost_empty)) m_pause = 1'b0;
    @(posedge clk);
    #1;
    compareModel();
  endtask

  task automatic resetModel();
    model_q.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_pause = 1'b0; m_valid = 1'b0; m_data = 10'h000;
  endtask

  initial begin
    logic [9:0] next_word;
    bit         biased_wr;

    // vector table: fill to full, overflow, drain, underflow, clear
    for (int i = 1; i <= 8; i++)
      vecs[i-1] = make_vec(1'b1, 10'(i), 1'b0, 1'b0, 4'(i), i == 8, 1'b0, i >= 6,
                           1'b0, 1'b0, 1'b0, 10'h000);
    vecs[8] = make_vec(1'b1, 10'h009, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1,
                       1'b1, 1'b0, 1'b0, 10'h000);
    for (int k = 1; k <= 8; k++)
      vecs[8+k] = make_vec(1'b0, 10'h000, 1'b1, 1'b0, 4'(8 - k), 1'b0, k == 8, k <= 5,
                           1'b1, 1'b0, 1'b1, 10'(k));
    vecs[17] = make_vec(1'b0, 10'h000, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0,
                        1'b1, 1'b1, 1'b0, 10'h008);
    vecs[18] = make_vec(1'b0, 10'h000, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0,
                        1'b0, 1'b0, 1'b0, 10'h008);

    reset = 1'b0; write = 1'b0; read = 1'b0; err_clear = 1'b0; data_in_push = 10'h000;
    th_almost_full = 4'd6; th_almost_empty = 4'd2;
    resetModel();
    #12;
    compareModel();
    checkOutput("reset_empty", int'(fifo_empty), 1);
    #10;
    reset = 1'b1;

    $display("[TB] vector table");
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].din, vecs[i].rd, vecs[i].clr);
      checkOutput($sformatf("tbl%0d_count", i), int'(fifo_count), int'(vecs[i].exp_count));
      checkOutput($sformatf("tbl%0d_full", i), int'(fifo_full), int'(vecs[i].exp_full));
      checkOutput($sformatf("tbl%0d_empty", i), int'(fifo_empty), int'(vecs[i].exp_empty));
      checkOutput($sformatf("tbl%0d_pause", i), int'(fifo_pause), int'(vecs[i].exp_pause));
      checkOutput($sformatf("tbl%0d_ovf", i), int'(err_overflow), int'(vecs[i].exp_ovf));
      checkOutput($sformatf("tbl%0d_unf", i), int'(err_underflow), int'(vecs[i].exp_unf));
`ifndef FIFO_FWFT_EN
      checkOutput($sformatf("tbl%0d_valid", i), int'(data_valid), int'(vecs[i].exp_valid));
      checkOutput($sformatf("tbl%0d_data", i), int'(data_out_pop), int'(vecs[i].exp_data));
`endif
    end

    $display("[TB] hysteresis");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 10'(16 + i), 1'b0, 1'b0);
    checkOutput("hyst_pause_at5", int'(fifo_pause), 0);
    applyStimulus(1'b1, 10'h020, 1'b0, 1'b0);
    checkOutput("hyst_pause_at6", int'(fifo_pause), 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
    checkOutput("hyst_pause_at3", int'(fifo_pause), 1);
    applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
    checkOutput("hyst_pause_at2", int'(fifo_pause), 0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);

    $display("[TB] simultaneous push/pop with wrap");
    next_word = 10'h100;
    for (int i = 0; i < 4; i++) begin applyStimulus(1'b1, next_word, 1'b0, 1'b0); next_word++; end
    for (int i = 0; i < 20; i++) begin applyStimulus(1'b1, next_word, 1'b1, 1'b0); next_word++; end
    checkOutput("wrap_count", int'(fifo_count), 4);
    for (int i = 0; i < 4; i++) begin applyStimulus(1'b1, next_word, 1'b0, 1'b0); next_word++; end
    applyStimulus(1'b1, next_word, 1'b1, 1'b0);
    checkOutput("full_wr_rd_count", int'(fifo_count), 7);
    checkOutput("full_wr_rd_ovf", int'(err_overflow), 1);
    applyStimulus(1'b0, 10'h000, 1'b0, 1'b1);
    applyStimulus(1'b0, 10'h000, 1'b0, 1'b1);
    checkOutput("clear_idle_ovf", int'(err_overflow), 0);
    applyStimulus(1'b1, 10'h1AA, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'h1AB, 1'b0, 1'b1);
    checkOutput("clear_vs_ovf", int'(err_overflow), 1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
    applyStimulus(1'b1, 10'h2CC, 1'b1, 1'b0);
    checkOutput("empty_wr_rd_count", int'(fifo_count), 1);
    checkOutput("empty_wr_rd_unf", int'(err_underflow), 1);

    $display("[TB] asynchronous reset mid-burst");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 10'(48 + i), 1'b0, 1'b0);
    write = 1'b1; read = 1'b1;
    #2 reset = 1'b0;
    #1;
    resetModel();
    compareModel();
    checkOutput("async_rst_count", int'(fifo_count), 0);
    checkOutput("async_rst_unf", int'(err_underflow), 0);
    write = 1'b0; read = 1'b0;
    #2 reset = 1'b1;
`ifdef FIFO_FWFT_EN
    applyStimulus(1'b1, 10'h155, 1'b0, 1'b0);
    checkOutput("fwft_valid", int'(data_valid), 1);
    checkOutput("fwft_data", int'(data_out_pop), 32'h155);
    applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
    checkOutput("fwft_empty", int'(fifo_empty), 1);
`endif

    $display("[TB] randomised traffic");
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 31) == 0) begin
        th_almost_full  = 4'($urandom_range(1, 9));
        th_almost_empty = 4'($urandom_range(0, 8));
      end
      biased_wr = ((n / 100) % 2) == 0;
      applyStimulus($urandom_range(0, 99) < (biased_wr ? 70 : 30), 10'($urandom),
                    $urandom_range(0, 99) < (biased_wr ? 30 : 70),
                    $urandom_range(0, 39) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
